// File: rtl/sequenciador_io.sv
// Execution/I-O sequencer: stalls the PC on In until a debounced button press captures
// the switches, latches the display on Out, and freezes the core on Break until reset.
module sequenciador_io #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 16,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              In,
  input  logic              Out,
  input  logic              Break,
  input  logic              EscreveReg,
  input  logic              botao,
  input  logic [SW_W-1:0]   chaves,
  input  logic [DATA_W-1:0] dado_out,
  output logic              habilitaPC,
  output logic              escreveRegFinal,
  output logic              selIn,
  output logic [DATA_W-1:0] dado_in,
  output logic [DATA_W-1:0] display,
  output logic              display_valido,
  output logic              esperando,
  output logic              parado,
  output logic [1:0]        estado
);

  localparam logic [1:0] EXEC       = 2'b00;
  localparam logic [1:0] ESPERA_IN  = 2'b01;
  localparam logic [1:0] ESCREVE_IN = 2'b10;
  localparam logic [1:0] PARADO     = 2'b11;

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]        estado_q, estado_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic [DATA_W-1:0] dado_in_q, dado_in_d;
  logic              valido_q, valido_d;

  // Debounce: a new level is accepted only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    estado_d        = estado_q;
    habilitaPC      = 1'b0;
    escreveRegFinal = 1'b0;
    selIn           = 1'b0;
    display_d       = display_q;
    valido_d        = valido_q;
    dado_in_d       = dado_in_q;
    case (estado_q)
      EXEC: begin
        habilitaPC      = ~(In | Break);
        escreveRegFinal = EscreveReg & ~In & ~Break;
        if (Out) begin
          display_d = dado_out;
          valido_d  = 1'b1;
        end
        if (Break)   estado_d = PARADO;
        else if (In) estado_d = ESPERA_IN;
      end
      ESPERA_IN: begin
        if (press_q) begin
          dado_in_d = DATA_W'(chaves);
          estado_d  = ESCREVE_IN;
        end
      end
      ESCREVE_IN: begin
        selIn           = 1'b1;
        escreveRegFinal = 1'b1;
        habilitaPC      = 1'b1;
        estado_d        = EXEC;
      end
      PARADO:  estado_d = PARADO;
      default: estado_d = EXEC;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
      estado_q  <= EXEC;
      display_q <= '0;
      dado_in_q <= '0;
      valido_q  <= 1'b0;
    end else begin
      sync1_q   <= botao;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
      estado_q  <= estado_d;
      display_q <= display_d;
      dado_in_q <= dado_in_d;
      valido_q  <= valido_d;
    end
  end

  assign dado_in        = dado_in_q;
  assign display        = display_q;
  assign display_valido = valido_q;
  assign esperando      = (estado_q == ESPERA_IN);
  assign parado         = (estado_q == PARADO);
  assign estado         = estado_q;

endmodule

// File: tb/tb_sequenciador_io.sv
// Directed bench for sequenciador_io: button debounce timing, In/Out/Break sequencing, resets.
module tb_sequenciador_io;

  localparam logic [1:0] EXEC       = 2'b00;
  localparam logic [1:0] ESPERA_IN  = 2'b01;
  localparam logic [1:0] ESCREVE_IN = 2'b10;
  localparam logic [1:0] PARADO     = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        In, Out, Break, EscreveReg, botao;
  logic [15:0] chaves;
  logic [31:0] dado_out;
  logic        habilitaPC, escreveRegFinal, selIn;
  logic [31:0] dado_in, display;
  logic        display_valido, esperando, parado;
  logic [1:0]  estado;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  sequenciador_io #(.DATA_W(32), .SW_W(16), .DEBOUNCE_CYC(4)) dut (
    .clock(clock), .reset_n(reset_n), .In(In), .Out(Out), .Break(Break),
    .EscreveReg(EscreveReg), .botao(botao), .chaves(chaves), .dado_out(dado_out),
    .habilitaPC(habilitaPC), .escreveRegFinal(escreveRegFinal), .selIn(selIn),
    .dado_in(dado_in), .display(display), .display_valido(display_valido),
    .esperando(esperando), .parado(parado), .estado(estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    n_checks++;
    assert (estado === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, estado, exp);
    end
  endtask

  // Waits (bounded) for the write cycle, then pops the expected switch capture.
  task automatic wait_write(input string tag, input int budget);
    bit          seen;
    logic [31:0] exp;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (selIn === 1'b1) seen = 1'b1;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check1({tag, "_seen"}, seen, 1'b1);
    if (seen) begin
      check32({tag, "_dado_in"}, dado_in, exp);
      check1({tag, "_wr"}, escreveRegFinal, 1'b1);
      check1({tag, "_pc"}, habilitaPC, 1'b1);
    end
  endtask

  initial begin
    reset_n = 1'b0; In = 1'b0; Out = 1'b0; Break = 1'b0; EscreveReg = 1'b0;
    botao = 1'b0; chaves = '0; dado_out = '0;
    repeat (3) tick();
    check_state("rst_state", EXEC);
    check32("rst_display", display, 32'h0);
    check1("rst_valido", display_valido, 1'b0);
    check32("rst_dado_in", dado_in, 32'h0);
    check1("rst_pc", habilitaPC, 1'b1);
    reset_n = 1'b1;
    tick();

    // Write-enable gating in EXEC.
    EscreveReg = 1'b1; #1;
    check1("exec_wr", escreveRegFinal, 1'b1);
    check1("exec_pc", habilitaPC, 1'b1);
    In = 1'b1; #1;
    check1("in_wr_gated", escreveRegFinal, 1'b0);
    check1("in_pc_stall", habilitaPC, 1'b0);

    // Press latency: pulse 6 cycles after the raw edge, write on the next cycle.
    chaves = 16'hA5A5;
    exp_q.push_back(32'h0000_A5A5);
    tick();
    check_state("enter_espera", ESPERA_IN);
    botao = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("wait_esperando", esperando, 1'b1);
      check1("wait_pc", habilitaPC, 1'b0);
    end
    tick();
    check1("pulse_cycle_esperando", esperando, 1'b1);
    check1("pulse_cycle_selin", selIn, 1'b0);
    tick();
    check1("write_selin", selIn, 1'b1);
    check1("write_wr", escreveRegFinal, 1'b1);
    check1("write_pc", habilitaPC, 1'b1);
    check32("write_dado_in", dado_in, exp_q.pop_front());
    In = 1'b0;
    tick();
    check_state("after_write", EXEC);
    tick();
    botao = 1'b0;
    repeat (10) tick();

    // 3-cycle glitch rejected, 5-cycle press accepted.
    In = 1'b1; chaves = 16'h1234;
    exp_q.push_back(32'h0000_1234);
    tick();
    botao = 1'b1;
    repeat (3) tick();
    botao = 1'b0;
    repeat (8) tick();
    check_state("glitch_still_waiting", ESPERA_IN);
    check1("glitch_no_write", selIn, 1'b0);
    botao = 1'b1;
    repeat (5) tick();
    botao = 1'b0;
    wait_write("press5", 20);
    In = 1'b0;
    tick();
    check_state("press5_exec", EXEC);
    repeat (10) tick();

    // Press during EXEC is discarded; a fresh release-then-press is needed.
    botao = 1'b1;
    repeat (10) tick();
    check_state("exec_press_ignored", EXEC);
    In = 1'b1; chaves = 16'hBEEF;
    exp_q.push_back(32'h0000_BEEF);
    tick();
    repeat (10) tick();
    check_state("held_no_retrigger", ESPERA_IN);
    botao = 1'b0;
    repeat (10) tick();
    check_state("release_waiting", ESPERA_IN);
    botao = 1'b1;
    repeat (5) tick();
    botao = 1'b0;
    wait_write("repress", 20);
    In = 1'b0;
    tick();
    repeat (10) tick();

    // Out latches display without stalling.
    Out = 1'b1; dado_out = 32'hDEAD_BEEF; #1;
    check1("out_pc", habilitaPC, 1'b1);
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    check32("out_display", display, exp_q.pop_front());
    check1("out_valido", display_valido, 1'b1);
    check1("out_pc_after", habilitaPC, 1'b1);
    Out = 1'b0;

    // Reset mid-wait returns to EXEC and clears registers.
    In = 1'b1;
    tick();
    check1("pre_reset_esperando", esperando, 1'b1);
    reset_n = 1'b0; In = 1'b0; #1;
    check_state("midwait_rst_state", EXEC);
    check1("midwait_rst_pc", habilitaPC, 1'b1);
    check32("midwait_rst_display", display, 32'h0);
    check1("midwait_rst_valido", display_valido, 1'b0);
    check32("midwait_rst_dado_in", dado_in, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Break with Out: display updates, core halts and ignores everything afterwards.
    Break = 1'b1; Out = 1'b1; dado_out = 32'hCAFE_F00D; #1;
    check1("break_pc", habilitaPC, 1'b0);
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    check32("break_display", display, exp_q.pop_front());
    check1("break_parado", parado, 1'b1);
    Break = 1'b0; In = 1'b1; dado_out = 32'h1111_1111; EscreveReg = 1'b1;
    for (int i = 0; i < 20; i++) begin
      botao = (i >= 2 && i < 10) ? 1'b1 : 1'b0;
      tick();
    end
    check1("halt_parado", parado, 1'b1);
    check1("halt_pc", habilitaPC, 1'b0);
    check1("halt_wr", escreveRegFinal, 1'b0);
    check32("halt_display", display, 32'hCAFE_F00D);
    check_state("halt_state", PARADO);
    In = 1'b0; Out = 1'b0; #1;
    reset_n = 1'b0; #1;
    check_state("halt_rst_state", EXEC);
    check1("halt_rst_parado", parado, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check1("after_halt_pc", habilitaPC, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
